mem_arbiter: RTL and testbench

- Shares the single Avalon-style memory port (address/byteenable/read/write/writedata, waitrequest, 1-cycle registered readdata) between the CPU instruction-fetch and data-access ports.
- Sits between the CPU core and the memory slave; serialises requests with round-robin on ties.
- Holds master signals stable through waitrequest stalls and returns a one-cycle ack per completed transfer.
- Guards against a wedged slave with a wait timeout.

---
 rtl/mem_arb_pkg.sv | 12 +
 rtl/mem_arb_rr2.sv | 22 ++
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_t;
  typedef enum logic {GntInstr, GntData} grant_t;
  typedef enum logic {OpRead, OpWrite} op_t;

  // Wide enough for any supported data width; sliced to DATA_W/8 by users.
  localparam int unsigned MaxBeW = 64;
  localparam logic [MaxBeW-1:0] BE_ALL = '1;

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-input round-robin picker; the last-grant register lives in the parent.
module mem_arb_rr2
  import mem_arb_pkg::*;
(
  input  logic   req_i,
  input  logic   req_d,
  input  grant_t last_grant,
  output logic   grant_valid,
  output grant_t grant
);

  always_comb begin
    grant_valid = req_i | req_d;
    grant       = GntInstr;
    if (req_i && req_d) begin
      grant = (last_grant == GntInstr) ? GntData : GntInstr;
    end else if (req_d) begin
      grant = GntData;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises CPU fetch and data accesses onto one Avalon-style memory port,
// holding latched master signals through stalls and aborting wedged transfers.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ack,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W/8-1:0] d_byteenable,
  input  logic [DATA_W-1:0]   d_writedata,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                err,
  output logic [ADDR_W-1:0]   m_address,
  output logic [DATA_W/8-1:0] m_byteenable,
  output logic                m_read,
  output logic                m_write,
  output logic [DATA_W-1:0]   m_writedata,
  input  logic                m_waitrequest,
  input  logic [DATA_W-1:0]   m_readdata
);

  localparam int unsigned BeW   = DATA_W / 8;
  localparam int unsigned WaitW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  state_t            state_q, state_d;
  grant_t            last_grant_q, last_grant_d;
  grant_t            gnt_q, gnt_d;
  op_t               op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BeW-1:0]    be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;
  logic              err_q, err_d;

  logic              arb_valid;
  grant_t            arb_grant;
  logic [31:0]       wait_next;

  mem_arb_rr2 u_rr2 (
    .req_i       (i_req),
    .req_d       (d_read | d_write),
    .last_grant  (last_grant_q),
    .grant_valid (arb_valid),
    .grant       (arb_grant)
  );

  assign wait_next = 32'(wait_cnt_q) + 32'd1;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    op_d         = op_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    wait_cnt_d   = wait_cnt_q;
    err_d        = err_q;

    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          state_d      = StBusy;
          last_grant_d = arb_grant;
          gnt_d        = arb_grant;
          if (arb_grant == GntInstr) begin
            addr_d = i_addr;
            be_d   = BE_ALL[BeW-1:0];
            op_d   = OpRead;
          end else begin
            addr_d  = d_addr;
            be_d    = d_byteenable;
            wdata_d = d_writedata;
            // Simultaneous read and write is a requester bug; the write wins.
            op_d    = d_write ? OpWrite : OpRead;
          end
        end
      end
      StBusy: begin
        if (!m_waitrequest) begin
          state_d    = StResp;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + WaitW'(1);
          if (MAX_WAIT != 0 && wait_next == MAX_WAIT) begin
            state_d    = StResp;
            err_d      = 1'b1;
            wait_cnt_d = '0;
          end
        end
      end
      StResp: begin
        state_d = StIdle;
        err_d   = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= GntInstr;
      gnt_q        <= GntInstr;
      op_q         <= OpRead;
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      wait_cnt_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      wait_cnt_q   <= wait_cnt_d;
      err_q        <= err_d;
    end
  end

  assign m_address    = addr_q;
  assign m_byteenable = be_q;
  assign m_writedata  = wdata_q;
  assign m_read       = (state_q == StBusy) && (op_q == OpRead);
  assign m_write      = (state_q == StBusy) && (op_q == OpWrite);

  assign i_ack   = (state_q == StResp) && (gnt_q == GntInstr);
  assign d_ack   = (state_q == StResp) && (gnt_q == GntData);
  // err_q is only ever set on the way into RESP.
  assign err     = err_q;
  assign i_rdata = m_readdata;
  assign d_rdata = m_readdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a registered-read slave model and an ack scoreboard.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [3:0]  d_byteenable;
  logic [31:0] d_writedata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        err;
  logic [31:0] m_address;
  logic [3:0]  m_byteenable;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_writedata;
  logic        m_waitrequest;
  logic [31:0] m_readdata = '0;

  typedef struct packed {
    logic        is_d;
    logic        is_read;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  mem_arbiter #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .MAX_WAIT (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_req         (i_req),
    .i_addr        (i_addr),
    .i_ack         (i_ack),
    .i_rdata       (i_rdata),
    .d_read        (d_read),
    .d_write       (d_write),
    .d_addr        (d_addr),
    .d_byteenable  (d_byteenable),
    .d_writedata   (d_writedata),
    .d_ack         (d_ack),
    .d_rdata       (d_rdata),
    .err           (err),
    .m_address     (m_address),
    .m_byteenable  (m_byteenable),
    .m_read        (m_read),
    .m_write       (m_write),
    .m_writedata   (m_writedata),
    .m_waitrequest (m_waitrequest),
    .m_readdata    (m_readdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] slave_data(input logic [31:0] a);
    return (a == 32'hBFC0_0000) ? 32'h2402_000A : (a ^ 32'h5A5A_5A5A);
  endfunction

  // Slave: read data registered in the cycle after acceptance.
  always @(posedge clk) begin
    if (m_read && !m_waitrequest) m_readdata <= slave_data(m_address);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic push_exp(input logic is_d, input logic is_read, input logic [31:0] rd,
                          input logic e);
    exp_t t;
    t.is_d    = is_d;
    t.is_read = is_read;
    t.rdata   = rd;
    t.err     = e;
    sb.push_back(t);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Counts negedges until an ack appears, bounded so a wedged DUT still reaches the summary.
  task automatic await_ack(input string tag, input int want);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (i_ack || d_ack) seen = 1'b1;
    end
    chk(tag, 64'(n), 64'(want));
  endtask

  always @(negedge clk) begin
    if (i_ack || d_ack) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_ack", 64'({i_ack, d_ack}), 64'(0));
      end else begin
        mon_e = sb.pop_front();
        chk("sb_port", 64'({i_ack, d_ack}), mon_e.is_d ? 64'(2'b01) : 64'(2'b10));
        chk("sb_err", 64'(err), 64'(mon_e.err));
        if (mon_e.is_read && !mon_e.err) begin
          chk("sb_rdata", 64'(mon_e.is_d ? d_rdata : i_rdata), 64'(mon_e.rdata));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; i_req = 1'b0; i_addr = '0; d_read = 1'b0; d_write = 1'b0;
    d_addr = '0; d_byteenable = '0; d_writedata = '0; m_waitrequest = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_m_read", 64'(m_read), 64'(0));
    chk("rst_m_write", 64'(m_write), 64'(0));
    chk("rst_m_address", 64'(m_address), 64'(0));
    chk("rst_m_be", 64'(m_byteenable), 64'(0));
    chk("rst_m_wdata", 64'(m_writedata), 64'(0));
    chk("rst_acks_err", 64'({i_ack, d_ack, err}), 64'(0));
    next_cycle();
    reset = 1'b0;

    // Instruction read, no stalls.
    next_cycle();
    i_req = 1'b1; i_addr = 32'hBFC0_0000;
    push_exp(1'b0, 1'b1, 32'h2402_000A, 1'b0);
    @(negedge clk);
    chk("t1_c0_m_read", 64'(m_read), 64'(0));
    @(negedge clk);
    chk("t1_c1_m_read", 64'(m_read), 64'(1));
    chk("t1_c1_m_be", 64'(m_byteenable), 64'(4'hF));
    chk("t1_c1_m_addr", 64'(m_address), 64'(32'hBFC0_0000));
    chk("t1_c1_no_ack", 64'({i_ack, d_ack}), 64'(0));
    @(negedge clk);
    chk("t1_c2_i_ack", 64'(i_ack), 64'(1));
    chk("t1_c2_d_ack", 64'(d_ack), 64'(0));
    chk("t1_c2_m_read", 64'(m_read), 64'(0));
    next_cycle();
    i_req = 1'b0;
    @(negedge clk);
    chk("t1_c3_i_ack", 64'(i_ack), 64'(0));

    // Data write with three stall cycles.
    next_cycle();
    d_write = 1'b1; d_addr = 32'h0000_0010; d_byteenable = 4'h3;
    d_writedata = 32'hDEAD_BEEF; m_waitrequest = 1'b1;
    push_exp(1'b1, 1'b0, 32'h0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      if (k == 4) m_waitrequest = 1'b0;
      @(negedge clk);
      chk("t2_m_write", 64'(m_write), 64'(1));
      chk("t2_m_addr", 64'(m_address), 64'(32'h0000_0010));
      chk("t2_m_be", 64'(m_byteenable), 64'(4'h3));
      chk("t2_m_wdata", 64'(m_writedata), 64'(32'hDEAD_BEEF));
      chk("t2_no_ack", 64'(d_ack), 64'(0));
    end
    @(negedge clk);
    chk("t2_c5_d_ack", 64'(d_ack), 64'(1));
    chk("t2_c5_m_write", 64'(m_write), 64'(0));
    next_cycle();
    d_write = 1'b0;

    // Tie after reset: DATA, INSTR, DATA, three cycles apart.
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    next_cycle();
    i_req = 1'b1; i_addr = 32'h0000_0100; d_read = 1'b1; d_addr = 32'h0000_0200;
    push_exp(1'b1, 1'b1, slave_data(32'h0000_0200), 1'b0);
    push_exp(1'b0, 1'b1, slave_data(32'h0000_0100), 1'b0);
    push_exp(1'b1, 1'b1, slave_data(32'h0000_0200), 1'b0);
    await_ack("t3_gap1", 3);
    chk("t3_first_d", 64'({i_ack, d_ack}), 64'(2'b01));
    await_ack("t3_gap2", 3);
    chk("t3_second_i", 64'({i_ack, d_ack}), 64'(2'b10));
    await_ack("t3_gap3", 3);
    chk("t3_third_d", 64'({i_ack, d_ack}), 64'(2'b01));
    next_cycle();
    i_req = 1'b0; d_read = 1'b0;

    // d_addr changes during a stalled read.
    next_cycle();
    d_read = 1'b1; d_addr = 32'h0000_0020; m_waitrequest = 1'b1;
    push_exp(1'b1, 1'b1, slave_data(32'h0000_0020), 1'b0);
    for (int k = 1; k <= 3; k++) begin
      next_cycle();
      if (k == 1) d_addr = 32'h0000_FFF0;
      if (k == 3) m_waitrequest = 1'b0;
      @(negedge clk);
      chk("t4_m_addr_held", 64'(m_address), 64'(32'h0000_0020));
      chk("t4_m_read", 64'(m_read), 64'(1));
    end
    @(negedge clk);
    chk("t4_d_ack", 64'(d_ack), 64'(1));
    next_cycle();
    d_read = 1'b0;

    // Timeout: waitrequest stuck high.
    next_cycle();
    d_read = 1'b1; d_addr = 32'h0000_0030; m_waitrequest = 1'b1;
    push_exp(1'b1, 1'b1, 32'h0, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      @(negedge clk);
      chk("t5_m_read", 64'(m_read), 64'(1));
      chk("t5_no_ack", 64'({d_ack, err}), 64'(0));
    end
    @(negedge clk);
    chk("t5_d_ack", 64'(d_ack), 64'(1));
    chk("t5_err", 64'(err), 64'(1));
    chk("t5_resp_m_read", 64'(m_read), 64'(0));
    next_cycle();
    d_read = 1'b0; m_waitrequest = 1'b0;
    @(negedge clk);
    chk("t5_err_clear", 64'({d_ack, err}), 64'(0));

    // Reset in BUSY abandons the transfer; last grant returns to INSTR.
    next_cycle();
    d_read = 1'b1; d_addr = 32'h0000_0040; m_waitrequest = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("t6_busy_m_read", 64'(m_read), 64'(1));
    next_cycle();
    reset = 1'b1; d_read = 1'b0; m_waitrequest = 1'b0;
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("t6_m_read_drop", 64'(m_read), 64'(0));
    chk("t6_no_ack", 64'({i_ack, d_ack}), 64'(0));
    @(negedge clk);
    chk("t6_still_no_ack", 64'({i_ack, d_ack, m_read}), 64'(0));
    next_cycle();
    i_req = 1'b1; i_addr = 32'h0000_0050; d_read = 1'b1; d_addr = 32'h0000_0060;
    push_exp(1'b1, 1'b1, slave_data(32'h0000_0060), 1'b0);
    await_ack("t6_tie_gap", 3);
    chk("t6_tie_data", 64'({i_ack, d_ack}), 64'(2'b01));
    next_cycle();
    i_req = 1'b0; d_read = 1'b0;

    repeat (3) next_cycle();
    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
